// File: rtl/popcnt_pkg.sv
// Shared constants and FSM state encoding for the streaming popcount controller.
package popcnt_pkg;

    localparam int WORD_W = 32;
    localparam int HW_W   = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/hamm32.sv
// Combinational 32-bit population count unit; the result covers 0..32.
import popcnt_pkg::*;

module hamm32 (
    input  logic [WORD_W-1:0] word,
    output logic [HW_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WORD_W; i++) begin
            count = count + {{(HW_W-1){1'b0}}, word[i]};
        end
    end

endmodule

// File: rtl/popcnt_stream_ctrl.sv
// Accumulates the popcount (or Hamming distance) of a multi-word job streamed over
// valid/ready, using one shared combinational hamm32 unit, and pulses done when complete.
import popcnt_pkg::*;

module popcnt_stream_ctrl #(
    parameter int LEN_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 mode,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    a_in,
    input  logic [WORD_W-1:0]    b_in,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W+4:0]     result,
    output logic [LEN_W-1:0]     words_left
);

    localparam int CNT_W = LEN_W + 5;

    state_t            state, state_nxt;
    logic              mode_q;
    logic              xfer;
    logic [WORD_W-1:0] operand;
    logic [HW_W-1:0]   hw;

    assign operand = mode_q ? (a_in ^ b_in) : a_in;

    hamm32 u_hamm32 (
        .word  (operand),
        .count (hw)
    );

    assign xfer = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (len != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort)                                   state_nxt = S_IDLE;
                else if (xfer && words_left == LEN_W'(1))    state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Abort wins over a same-cycle transfer, so the accumulator only moves on a clean transfer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            state      <= S_IDLE;
            result     <= '0;
            words_left <= '0;
            mode_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        result     <= '0;
                        words_left <= len;
                        mode_q     <= mode;
                    end
                end
                S_RUN: begin
                    if (!abort && xfer) begin
                        result     <= result + {{(CNT_W-HW_W){1'b0}}, hw};
                        words_left <= words_left - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_popcnt_stream_ctrl.sv
// Scoreboard bench: the driver queues the model's expected total per completed job,
// and an independent monitor compares it whenever done pulses.
module tb_popcnt_stream_ctrl;

    localparam int LEN_W = 5;
    localparam int CNT_W = LEN_W + 5;
    localparam int MAXW  = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             mode = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      a_in = '0;
    logic [31:0]      b_in = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] result;
    logic [LEN_W-1:0] words_left;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic [31:0] wa[MAXW];
    logic [31:0] wb[MAXW];

    popcnt_stream_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .mode(mode),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result(result), .words_left(words_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("result", 32'(result), 32'(exp_q.pop_front()));
                check("words_left_at_done", 32'(words_left), 32'd0);
            end
        end
    end

    function automatic int model(input int n, input bit m);
        int sum = 0;
        for (int i = 0; i < n; i++) sum += $countones(m ? (wa[i] ^ wb[i]) : wa[i]);
        return sum;
    endfunction

    // abort_at < 0 means run to completion; start_in_done pokes start during the DONE cycle.
    task automatic do_job(input int n, input bit m, input int stall_max,
                          input int abort_at, input bit start_in_done);
        if (abort_at < 0) exp_q.push_back(model(n, m));
        start = 1'b1; len = LEN_W'(n); mode = m;
        tick();
        start = 1'b0; len = LEN_W'($urandom); mode = 1'($urandom);
        if (n == 0) begin
            check("len0_in_ready", 32'(in_ready), 32'd0);
            check("len0_done", 32'(done), 32'd1);
        end else begin
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(stall_max, 0)) begin
                    in_valid = 1'b0; a_in = $urandom; b_in = $urandom;
                    check("stall_in_ready", 32'(in_ready), 32'd1);
                    tick();
                end
                check("words_left_run", 32'(words_left), 32'(n - i));
                in_valid = 1'b1; a_in = wa[i]; b_in = wb[i];
                if (i == abort_at) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0; in_valid = 1'b0;
                    check("abort_busy", 32'(busy), 32'd0);
                    check("abort_no_done", 32'(done), 32'd0);
                    return;
                end
                check("run_in_ready", 32'(in_ready), 32'd1);
                tick();
            end
            in_valid = 1'b0;
            check("done_after_last", 32'(done), 32'd1);
            check("done_in_ready", 32'(in_ready), 32'd0);
        end
        if (start_in_done) begin
            start = 1'b1; len = LEN_W'(3);
        end
        tick();
        start = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    task automatic set_words(input int n, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] b0, input logic [31:0] b1);
        wa[0] = a0; wa[1] = a1; wa[2] = a2;
        wb[0] = b0; wb[1] = b1; wb[2] = '0;
        for (int i = 3; i < n; i++) begin wa[i] = $urandom; wb[i] = $urandom; end
    endtask

    initial begin
        tick(); tick();
        check("rst_result", 32'(result), 32'd0);
        check("rst_words_left", 32'(words_left), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        set_words(3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, '0, '0);
        do_job(3, 1'b0, 0, -1, 1'b0);
        check("hold_after_done", 32'(result), 32'd34);

        set_words(2, 32'hF0F0_F0F0, 32'hAAAA_AAAA, '0, 32'h0F0F_0F0F, 32'hAAAA_AAAA);
        do_job(2, 1'b1, 0, -1, 1'b0);

        set_words(2, 32'h0000_00FF, 32'h0000_000F, '0, '0, '0);
        do_job(2, 1'b0, 3, -1, 1'b0);

        do_job(0, 1'b0, 0, -1, 1'b0);
        check("len0_result", 32'(result), 32'd0);

        set_words(4, $urandom, $urandom, $urandom, $urandom, $urandom);
        do_job(4, 1'b0, 1, 2, 1'b0);
        set_words(1, 32'h0000_0007, '0, '0, '0, '0);
        do_job(1, 1'b0, 0, -1, 1'b0);
        check("post_abort_result", 32'(result), 32'd3);

        // Mid-job reset after one word of a five-word job.
        set_words(5, 32'hFFFF_0000, $urandom, $urandom, '0, '0);
        start = 1'b1; len = LEN_W'(5); tick();
        start = 1'b0; in_valid = 1'b1; a_in = wa[0]; tick();
        in_valid = 1'b0; rst_n = 1'b0; tick();
        rst_n = 1'b1;
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_words_left", 32'(words_left), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();

        set_words(2, 32'h1, 32'h3, '0, '0, '0);
        do_job(2, 1'b0, 0, -1, 1'b1);
        tick();
        check("start_in_done_ignored", 32'(busy), 32'd0);

        for (int i = 0; i < MAXW; i++) begin wa[i] = '1; wb[i] = '0; end
        do_job(MAXW, 1'b0, 0, -1, 1'b0);
        check("max_result", 32'(result), 32'(32 * MAXW));

        for (int j = 0; j < 25; j++) begin
            int n = $urandom_range(MAXW, 1);
            for (int i = 0; i < n; i++) begin wa[i] = $urandom; wb[i] = $urandom; end
            do_job(n, 1'($urandom), 2, ($urandom_range(5, 0) == 0) ? $urandom_range(n - 1, 0) : -1, 1'($urandom));
            repeat ($urandom_range(2, 0)) tick();
        end

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
